// File: rtl/field_blink_edit_if.sv
// Field-edit bus: selection/button/tick requests toward the editor and
// the registered LED, counter and strobe outputs coming back.
//   master : drives gt_mod, cdb_up, cdb_dw, ena2hz; observes the rest
//   slave  : the editor itself
interface field_blink_edit_if #(
  parameter int unsigned NF  = 3,
  parameter int unsigned LPF = 4,
  parameter int unsigned CW  = 5
);
  logic [2:0]        gt_mod;
  logic              cdb_up;
  logic              cdb_dw;
  logic              ena2hz;
  logic [CW-1:0]     q;
  logic [NF*LPF-1:0] ena_led;
  logic [NF-1:0]     inc_pulse;
  logic [NF-1:0]     dec_pulse;
  logic              timeout;
  logic              editing;

  modport master (
    output gt_mod, cdb_up, cdb_dw, ena2hz,
    input  q, ena_led, inc_pulse, dec_pulse, timeout, editing
  );

  modport slave (
    input  gt_mod, cdb_up, cdb_dw, ena2hz,
    output q, ena_led, inc_pulse, dec_pulse, timeout, editing
  );
endinterface

// File: rtl/field_blink_edit.sv
// Field editor: blinks the LED group of the selected field, issues
// per-field increment/decrement strobes, and locks out after IDLE_MOD
// idle blink ticks until the selection is released.
//   ckht : clock, all state changes on the falling edge
//   rst  : asynchronous active-high reset
//   bus  : field_blink_edit_if slave (selection, buttons, tick in;
//          q, ena_led, inc/dec strobes, timeout, editing out)
module field_blink_edit #(
  parameter int unsigned     NF       = 3,
  parameter int unsigned     LPF      = 4,
  parameter logic [LPF-1:0]  BLK_MASK = 4'b0110,
  parameter int unsigned     IDLE_MOD = 20
) (
  input  logic               ckht,
  input  logic               rst,
  field_blink_edit_if.slave  bus
);
  localparam int unsigned SW = 3;
  localparam int unsigned CW = $clog2(IDLE_MOD);
  localparam int unsigned LW = NF * LPF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EDIT = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   q_q, q_d;
  logic [LW-1:0]   ena_led_q, ena_led_d;
  logic [NF-1:0]   inc_pulse_q, inc_pulse_d;
  logic [NF-1:0]   dec_pulse_q, dec_pulse_d;
  logic            timeout_q, timeout_d;
  logic            editing_q, editing_d;

  logic            sel_ok;
  logic            any_btn;
  logic [LW-1:0]   blink_mask;

  assign sel_ok  = (bus.gt_mod != '0) && (bus.gt_mod <= SW'(NF));
  assign any_btn = bus.cdb_up | bus.cdb_dw;

  // Blink bits of the currently latched field's group
  always_comb begin
    blink_mask = '0;
    for (int k = 0; k < int'(NF); k++) begin
      if (sel_q == SW'(k + 1)) begin
        blink_mask[k*LPF +: LPF] = BLK_MASK;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    q_d         = q_q;
    ena_led_d   = ena_led_q;
    inc_pulse_d = '0;
    dec_pulse_d = '0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        q_d       = '0;
        ena_led_d = '1;
        if (sel_ok) begin
          state_d = S_EDIT;
          sel_d   = bus.gt_mod;
        end
      end

      S_EDIT: begin
        if (!sel_ok) begin
          state_d   = S_IDLE;
          q_d       = '0;
          ena_led_d = '1;
        end else if (bus.gt_mod != sel_q) begin
          // Field switch: restart cleanly on the new field, no strobe
          sel_d     = bus.gt_mod;
          q_d       = '0;
          ena_led_d = '1;
        end else if (any_btn) begin
          // Buttons win over the tick; only non-selected groups are
          // already all ones, so restoring everything is equivalent
          q_d       = '0;
          ena_led_d = '1;
          if (bus.cdb_up && !bus.cdb_dw) begin
            inc_pulse_d = NF'(1) << (sel_q - SW'(1));
          end
          if (bus.cdb_dw && !bus.cdb_up) begin
            dec_pulse_d = NF'(1) << (sel_q - SW'(1));
          end
        end else if (bus.ena2hz) begin
          if (q_q == CW'(IDLE_MOD - 1)) begin
            q_d       = '0;
            ena_led_d = '1;
            timeout_d = 1'b1;
            state_d   = S_LOCK;
          end else begin
            q_d       = q_q + CW'(1);
            ena_led_d = ena_led_q ^ blink_mask;
          end
        end
      end

      S_LOCK: begin
        q_d       = '0;
        ena_led_d = '1;
        if (!sel_ok) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        q_d       = '0;
        ena_led_d = '1;
      end
    endcase

    editing_d = (state_d == S_EDIT);
  end

  // State and output registers, falling edge
  always_ff @(negedge ckht or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      q_q         <= '0;
      ena_led_q   <= '1;
      inc_pulse_q <= '0;
      dec_pulse_q <= '0;
      timeout_q   <= 1'b0;
      editing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      q_q         <= q_d;
      ena_led_q   <= ena_led_d;
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
      timeout_q   <= timeout_d;
      editing_q   <= editing_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.ena_led   = ena_led_q;
  assign bus.inc_pulse = inc_pulse_q;
  assign bus.dec_pulse = dec_pulse_q;
  assign bus.timeout   = timeout_q;
  assign bus.editing   = editing_q;

endmodule

// File: tb/tb_field_blink_edit.sv
// Bench for field_blink_edit: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the editor.
module tb_field_blink_edit;
  localparam int unsigned NF   = 3;
  localparam int unsigned LPF  = 4;
  localparam int unsigned CW   = 5;
  localparam int unsigned IMOD = 20;
  localparam logic [3:0]  BLINK_PAT = 4'b1001;

  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_LOCK = 2;

  logic ckht;
  logic rst;

  field_blink_edit_if #(.NF(NF), .LPF(LPF), .CW(CW)) bus ();

  field_blink_edit #(
    .NF(NF), .LPF(LPF), .BLK_MASK(4'b0110), .IDLE_MOD(IMOD)
  ) dut (
    .ckht (ckht),
    .rst  (rst),
    .bus  (bus)
  );

  initial ckht = 1'b1;
  always #5 ckht = ~ckht;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_mode  = M_IDLE;
  int m_field = 0;
  int m_ticks = 0;
  int cur_gm  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_led();
    logic [11:0] v;
    v = 12'hFFF;
    // An odd number of ticks since the last restart shows the blink pattern
    if (m_mode == M_EDIT && (m_ticks % 2) == 1)
      v[(m_field-1)*4 +: 4] = BLINK_PAT;
    return v;
  endfunction

  // One clock: apply inputs, let the falling edge happen, compare
  task automatic step(input int gm, input bit up, input bit dw, input bit tk);
    bit valid;
    logic [2:0] e_inc, e_dec;
    bit e_to;
    bus.gt_mod = 3'(gm);
    bus.cdb_up = up;
    bus.cdb_dw = dw;
    bus.ena2hz = tk;
    cur_gm = gm;
    @(negedge ckht);
    #1;
    valid = (gm >= 1 && gm <= int'(NF));
    e_inc = '0;
    e_dec = '0;
    e_to  = 1'b0;
    case (m_mode)
      M_IDLE: if (valid) begin
        m_mode = M_EDIT; m_field = gm; m_ticks = 0;
      end
      M_LOCK: if (!valid) m_mode = M_IDLE;
      default: begin
        if (!valid) begin
          m_mode = M_IDLE; m_ticks = 0;
        end else if (gm != m_field) begin
          m_field = gm; m_ticks = 0;
        end else if (up || dw) begin
          m_ticks = 0;
          if (up && !dw) e_inc = 3'(1 << (m_field - 1));
          if (dw && !up) e_dec = 3'(1 << (m_field - 1));
        end else if (tk) begin
          m_ticks++;
          if (m_ticks == int'(IMOD)) begin
            m_ticks = 0; e_to = 1'b1; m_mode = M_LOCK;
          end
        end
      end
    endcase
    check("q",   32'(bus.q),         (m_mode == M_EDIT) ? 32'(m_ticks) : 32'd0);
    check("led", 32'(bus.ena_led),   32'(model_led()));
    check("inc", 32'(bus.inc_pulse), 32'(e_inc));
    check("dec", 32'(bus.dec_pulse), 32'(e_dec));
    check("tmo", 32'(bus.timeout),   32'(e_to));
    check("edit", 32'(bus.editing),  32'(m_mode == M_EDIT));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_q"},    32'(bus.q),         32'd0);
    check({tag, "_led"},  32'(bus.ena_led),   32'hFFF);
    check({tag, "_inc"},  32'(bus.inc_pulse), 32'd0);
    check({tag, "_dec"},  32'(bus.dec_pulse), 32'd0);
    check({tag, "_tmo"},  32'(bus.timeout),   32'd0);
    check({tag, "_edit"}, 32'(bus.editing),   32'd0);
  endtask

  initial begin
    int gm;
    rst = 1'b1;
    bus.gt_mod = '0;
    bus.cdb_up = 1'b0;
    bus.cdb_dw = 1'b0;
    bus.ena2hz = 1'b0;
    #12;
    check_reset_vals("rst_init");
    rst = 1'b0;

    // Field 2 blinks its group only
    step(2, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(2, 0, 0, 1);
    check("blink3_led", 32'(bus.ena_led), 32'hF9F);
    check("blink3_q",   32'(bus.q),       32'd3);
    step(0, 0, 0, 0);

    // Auto-exit after IMOD ticks, then lockout until released
    step(1, 0, 0, 0);
    for (int i = 0; i < int'(IMOD); i++) step(1, 0, 0, 1);
    check("lock_tmo", 32'(bus.timeout), 32'd1);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    check("lock_noinc", 32'(bus.inc_pulse), 32'd0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("unlock_inc", 32'(bus.inc_pulse), 32'b001);
    step(1, 0, 0, 0);

    // Field 3 increment after 7 ticks
    step(3, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(3, 0, 0, 1);
    step(3, 1, 0, 0);
    check("f3_inc", 32'(bus.inc_pulse), 32'b100);
    check("f3_led", 32'(bus.ena_led),   32'hFFF);
    step(3, 0, 0, 0);
    step(3, 0, 1, 0);
    step(3, 0, 0, 1);

    // Both buttons and tick together
    step(3, 0, 0, 1);
    step(3, 1, 1, 1);
    check("both_led", 32'(bus.ena_led), 32'hFFF);
    step(3, 0, 0, 0);

    // Field switch mid-blink
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("sw_pre", 32'(bus.ena_led), 32'hFF9);
    step(2, 0, 0, 0);
    step(2, 0, 0, 1);
    check("sw_post", 32'(bus.ena_led), 32'hF9F);

    // Asynchronous reset in the middle of EDIT
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_async");
    #2 rst = 1'b0;
    m_mode = M_IDLE; m_ticks = 0; m_field = 0;
    step(1, 0, 0, 0);

    // Randomized stimulus
    gm = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 2) gm = int'($urandom_range(0, 7));
      step(gm, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 45);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
